// File: rtl/spi_slave_cmd_decoder_if.sv
// rtl/spi_slave_cmd_decoder_if.sv - byte-stream, address and write-word signals of the SPI command decoder
interface spi_slave_cmd_decoder_if #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
);
    logic                      cs_ni;
    logic [7:0]                rx_byte_i;
    logic                      rx_byte_valid_i;
    logic [APB_ADDR_WIDTH-1:0] rxtx_addr_o;
    logic                      rxtx_addr_valid_o;
    logic                      start_tx_o;
    logic [APB_DATA_WIDTH-1:0] rx_data_o;
    logic                      rx_valid_o;
    logic                      rx_ready_i;
    logic [15:0]               wrap_length_o;
    logic                      overflow_o;

    // Side that feeds bytes and consumes decoded results.
    modport master (
        output cs_ni, rx_byte_i, rx_byte_valid_i, rx_ready_i,
        input  rxtx_addr_o, rxtx_addr_valid_o, start_tx_o,
        input  rx_data_o, rx_valid_o, wrap_length_o, overflow_o
    );

    // The decoder itself.
    modport slave (
        input  cs_ni, rx_byte_i, rx_byte_valid_i, rx_ready_i,
        output rxtx_addr_o, rxtx_addr_valid_o, start_tx_o,
        output rx_data_o, rx_valid_o, wrap_length_o, overflow_o
    );
endinterface

// File: rtl/spi_slave_cmd_decoder.sv
// rtl/spi_slave_cmd_decoder.sv - decodes SPI command/address/data bytes into address, write words and wrap length
module spi_slave_cmd_decoder #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32
) (
    input logic                    pclk_i,
    input logic                    preset_ni,
    spi_slave_cmd_decoder_if.slave bus
);
    localparam int ADDR_BYTES = APB_ADDR_WIDTH / 8;
    localparam int DATA_BYTES = APB_DATA_WIDTH / 8;
    // Shift register must hold the widest field, and at least the 16-bit wrap length.
    localparam int SW_AD = (APB_ADDR_WIDTH > APB_DATA_WIDTH) ? APB_ADDR_WIDTH : APB_DATA_WIDTH;
    localparam int SW    = (SW_AD > 16) ? SW_AD : 16;
    localparam int BC_MAX = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int BCW    = $clog2(BC_MAX + 1);

    localparam logic [BCW-1:0] ADDR_LAST = BCW'(ADDR_BYTES - 1);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BYTES - 1);
    localparam logic [BCW-1:0] WLEN_LAST = BCW'(1);

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h0B;
    localparam logic [7:0] CMD_WLEN  = 8'h11;

    typedef enum logic [2:0] {
        ST_CMD,
        ST_ADDR,
        ST_WLEN,
        ST_DATA,
        ST_IGNORE
    } state_t;

    state_t                    state_q, state_d;
    logic [BCW-1:0]            bc_q, bc_d;
    logic [SW-1:0]             shift_q, shift_d;
    logic                      is_read_q, is_read_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      addr_valid_q, addr_valid_d;
    logic                      start_tx_q, start_tx_d;
    logic [APB_DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                      rx_valid_q, rx_valid_d;
    logic [15:0]               wrap_q, wrap_d;
    logic                      ovf_q, ovf_d;
    logic [SW-1:0]             shift_nxt;

    // Next-state and output decode: one byte is consumed per qualified strobe while selected.
    always_comb begin
        state_d      = state_q;
        bc_d         = bc_q;
        shift_d      = shift_q;
        is_read_d    = is_read_q;
        addr_d       = addr_q;
        addr_valid_d = 1'b0;
        start_tx_d   = 1'b0;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        wrap_d       = wrap_q;
        ovf_d        = ovf_q;
        shift_nxt    = (shift_q << 8) | SW'(bus.rx_byte_i);

        // A pending word retires on its handshake; a newly completed word below may refill it.
        if (rx_valid_q && bus.rx_ready_i) begin
            rx_valid_d = 1'b0;
        end

        if (bus.cs_ni) begin
            state_d = ST_CMD;
            bc_d    = '0;
            shift_d = '0;
        end else if (bus.rx_byte_valid_i) begin
            case (state_q)
                ST_CMD: begin
                    bc_d    = '0;
                    shift_d = '0;
                    if (bus.rx_byte_i == CMD_WRITE) begin
                        state_d   = ST_ADDR;
                        is_read_d = 1'b0;
                    end else if (bus.rx_byte_i == CMD_READ) begin
                        state_d   = ST_ADDR;
                        is_read_d = 1'b1;
                    end else if (bus.rx_byte_i == CMD_WLEN) begin
                        state_d = ST_WLEN;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    shift_d = shift_nxt;
                    bc_d    = bc_q + 1'b1;
                    if (bc_q == ADDR_LAST) begin
                        addr_d       = shift_nxt[APB_ADDR_WIDTH-1:0];
                        addr_valid_d = 1'b1;
                        bc_d         = '0;
                        shift_d      = '0;
                        if (is_read_q) begin
                            start_tx_d = 1'b1;
                            state_d    = ST_IGNORE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    shift_d = shift_nxt;
                    bc_d    = bc_q + 1'b1;
                    if (bc_q == DATA_LAST) begin
                        bc_d    = '0;
                        shift_d = '0;
                        // Room exists if nothing is pending or the pending word is leaving this cycle.
                        if (!rx_valid_q || bus.rx_ready_i) begin
                            rx_data_d  = shift_nxt[APB_DATA_WIDTH-1:0];
                            rx_valid_d = 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                ST_WLEN: begin
                    shift_d = shift_nxt;
                    bc_d    = bc_q + 1'b1;
                    if (bc_q == WLEN_LAST) begin
                        wrap_d  = shift_nxt[15:0];
                        bc_d    = '0;
                        state_d = ST_IGNORE;
                    end
                end
                ST_IGNORE: begin
                    state_d = ST_IGNORE;
                end
                default: begin
                    state_d = ST_CMD;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge pclk_i or negedge preset_ni) begin
        if (!preset_ni) begin
            state_q      <= ST_CMD;
            bc_q         <= '0;
            shift_q      <= '0;
            is_read_q    <= 1'b0;
            addr_q       <= '0;
            addr_valid_q <= 1'b0;
            start_tx_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            wrap_q       <= 16'h0001;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            shift_q      <= shift_d;
            is_read_q    <= is_read_d;
            addr_q       <= addr_d;
            addr_valid_q <= addr_valid_d;
            start_tx_q   <= start_tx_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            wrap_q       <= wrap_d;
            ovf_q        <= ovf_d;
        end
    end

    assign bus.rxtx_addr_o       = addr_q;
    assign bus.rxtx_addr_valid_o = addr_valid_q;
    assign bus.start_tx_o        = start_tx_q;
    assign bus.rx_data_o         = rx_data_q;
    assign bus.rx_valid_o        = rx_valid_q;
    assign bus.wrap_length_o     = wrap_q;
    assign bus.overflow_o        = ovf_q;
endmodule

// File: doc/spi_slave_cmd_decoder.md
SPI_SLAVE_CMD_DECODER -- requirements
Module: spi_slave_cmd_decoder

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, meaning address width in bits; legal values are multiples of 8.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, meaning data word width in bits; legal values are multiples of 8.
REQ-003 SHALL have port pclk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port preset_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port cs_ni, input, 1 bit: SPI chip select, already synchronised to pclk_i, active low.
REQ-006 SHALL have port rx_byte_i, input, 8 bits: deserialised SPI byte.
REQ-007 SHALL have port rx_byte_valid_i, input, 1 bit: one-cycle strobe qualifying rx_byte_i.
REQ-008 SHALL have port rxtx_addr_o, output, APB_ADDR_WIDTH bits: decoded start address.
REQ-009 SHALL have port rxtx_addr_valid_o, output, 1 bit: one-cycle pulse that rxtx_addr_o is new.
REQ-010 SHALL have port start_tx_o, output, 1 bit: one-cycle read-start pulse.
REQ-011 SHALL have port rx_data_o, output, APB_DATA_WIDTH bits: assembled write word.
REQ-012 SHALL have port rx_valid_o, output, 1 bit: rx_data_o valid.
REQ-013 SHALL have port rx_ready_i, input, 1 bit: downstream accepts rx_data_o.
REQ-014 SHALL have port wrap_length_o, output, 16 bits: burst wrap length register.
REQ-015 SHALL have port overflow_o, output, 1 bit: sticky word-drop flag.

Function
REQ-016 SHALL implement states CMD, ADDR, WLEN, DATA, IGNORE, with a byte counter BC.
REQ-017 SHALL ignore rx_byte_valid_i whenever cs_ni is high.
REQ-018 SHALL, in CMD on a valid byte: 0x02 -> ADDR (write); 0x0B -> ADDR (read); 0x11 -> WLEN; any other value -> IGNORE; BC cleared.
REQ-019 SHALL shift address bytes MSB first; on byte APB_ADDR_WIDTH/8 it updates rxtx_addr_o and pulses rxtx_addr_valid_o on the next cycle.
REQ-020 SHALL, for a read, pulse start_tx_o in the same cycle as rxtx_addr_valid_o and then go to IGNORE.
REQ-021 SHALL, for a write, go to DATA after the last address byte.
REQ-022 SHALL, in DATA, shift bytes MSB first; on byte APB_DATA_WIDTH/8 it loads rx_data_o and sets rx_valid_o on the next cycle, clears BC, and stays in DATA.
REQ-023 SHALL hold rx_valid_o and rx_data_o stable until the cycle rx_valid_o && rx_ready_i, and clear rx_valid_o after that edge.
REQ-024 SHALL, when a word completes while rx_valid_o is high and rx_ready_i is low, drop the new word, keep the old one and set overflow_o.
REQ-025 SHALL load a new word when completion coincides with rx_valid_o && rx_ready_i, with rx_valid_o staying high and no overflow.
REQ-026 SHALL, in WLEN, take 2 bytes MSB first, write wrap_length_o on the second byte and then go to IGNORE.
REQ-027 SHALL store wrap_length_o as received, including 0x0000.
REQ-028 SHALL stay in IGNORE, discarding bytes, until cs_ni is high.
REQ-029 SHALL, while cs_ni is high, return any state to CMD next cycle, clear BC and discard the partial shift register.
REQ-030 SHALL keep a pending rx_valid_o word across cs_ni deassertion until it is accepted.
REQ-031 SHALL clear overflow_o only on a 0x11 command byte or on reset.
REQ-032 SHALL drive all outputs from registers.

Reset
REQ-033 SHALL, on preset_ni low, asynchronously set state CMD, BC 0, rxtx_addr_o 0, rxtx_addr_valid_o 0, start_tx_o 0, rx_data_o 0, rx_valid_o 0, wrap_length_o 0x0001 and overflow_o 0.
REQ-034 SHALL, on reset during a transfer, discard partial data, with the next cs_ni low starting in CMD.

Verification
REQ-035 SHALL cover a write: cs low, bytes 02 00 00 10 00 DE AD BE EF with rx_ready_i=1 -> one rxtx_addr_valid_o pulse with addr 0x00001000, then rx_valid_o with 0xDEADBEEF accepted once.
REQ-036 SHALL cover a read: bytes 0B 12 34 56 78 -> rxtx_addr_o 0x12345678, with rxtx_addr_valid_o and start_tx_o pulsing in the same cycle; further bytes are ignored.
REQ-037 SHALL cover backpressure: write of two words with rx_ready_i=0 -> the first word is held, the second is dropped, overflow_o=1; command 11 00 08 -> overflow_o=0 and wrap_length_o=0x0008.
REQ-038 SHALL cover abort: cs_ni high after 02 00 00 -> no address pulse; the next transaction 0B 00 00 00 04 decodes 0x00000004.
REQ-039 SHALL cover unknown command 0x55 followed by 8 bytes -> no output activity; reset mid-DATA -> all outputs at reset values and wrap_length_o=0x0001.
REQ-040 SHALL cover simultaneous completion: word 2 completes in the same cycle word 1 is accepted -> rx_data_o updates, rx_valid_o stays high and overflow_o=0.
